// File: rtl/controlador_requisicoes.sv
// controlador_requisicoes: host-side initiator for the shortest-path engine.
// Accepts (fonte, destino) requests, pulses the engine start command,
// buffers the path nodes it reports and streams them out with an end marker.
// Optional feature macro: INVERTER_CAMINHO_EN selects LIFO path order
// (source->destination) instead of the default FIFO streaming order.
//
// state   | meaning
// --------+---------------------------------------------------------------
// OCIOSO  | idle, request channel ready
// DISPARO | one-cycle start pulse to the engine with the latched addresses
// AGUARDA | capturing path nodes, timeout counter running
// ESVAZIA | draining the remaining buffered nodes
// ERRO    | one-cycle timeout report, buffer flushed
module controlador_requisicoes #(
    parameter int ADDR_WIDTH     = 6,
    parameter int MAX_CAMINHO    = 64,
    parameter int TIMEOUT_WIDTH  = 20,
    parameter int TIMEOUT_CICLOS = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [ADDR_WIDTH-1:0] req_fonte_in,
    input  logic [ADDR_WIDTH-1:0] req_destino_in,
    output logic                  top_wr_fonte_out,
    output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
    output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
    input  logic                  cam_valid_in,
    input  logic [ADDR_WIDTH-1:0] cam_addr_in,
    input  logic                  cam_pronto_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [ADDR_WIDTH-1:0] out_addr_out,
    output logic                  out_last_out,
    output logic                  erro_timeout_out,
    output logic                  erro_overflow_out,
    output logic                  ocupado_out
);
    localparam int PTR_W = $clog2(MAX_CAMINHO);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ULTIMO = TIMEOUT_WIDTH'(TIMEOUT_CICLOS - 1);
    localparam logic [CNT_W-1:0]         CNT_CHEIO  = CNT_W'(MAX_CAMINHO);
`ifdef INVERTER_CAMINHO_EN
    // read pointer tracks the top of the stack (one below the write pointer)
    localparam logic [PTR_W-1:0] RD_INICIAL = '1;
`else
    localparam logic [PTR_W-1:0] RD_INICIAL = '0;
`endif

    typedef enum logic [2:0] {OCIOSO, DISPARO, AGUARDA, ESVAZIA, ERRO} estado_t;

    estado_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]    fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0]    destino_q, destino_d;
    logic [ADDR_WIDTH-1:0]    mem_q [MAX_CAMINHO];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, wr_nxt;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CNT_W-1:0]         count_q, count_d, count_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                     ovf_q, ovf_d;
    logic                     push_req, push, pop, cheio;

    assign cheio = (count_q == CNT_CHEIO);

`ifdef INVERTER_CAMINHO_EN
    assign out_valid_out = (state_q == ESVAZIA) && (count_q != '0);
    assign wr_nxt        = wr_ptr_q + PTR_W'(push) - PTR_W'(pop);
    assign rd_nxt        = wr_nxt - 1'b1;
`else
    // while capturing, hold back the newest node so the marker can land on it
    assign out_valid_out = ((state_q == AGUARDA) && (count_q >= CNT_W'(2))) ||
                           ((state_q == ESVAZIA) && (count_q != '0));
    assign wr_nxt        = wr_ptr_q + PTR_W'(push);
    assign rd_nxt        = rd_ptr_q + PTR_W'(pop);
`endif

    assign out_last_out = (state_q == ESVAZIA) && (count_q == CNT_W'(1));
    assign out_addr_out = out_valid_out ? mem_q[rd_ptr_q] : '0;
    assign pop          = out_valid_out && out_ready_in;
    assign push_req     = (state_q == AGUARDA) && cam_valid_in;
    // a full buffer still accepts a node when one leaves in the same cycle
    assign push         = push_req && (!cheio || pop);
    assign count_nxt    = count_q + CNT_W'(push) - CNT_W'(pop);

    assign req_ready_out        = (state_q == OCIOSO) && !rst;
    assign top_wr_fonte_out     = (state_q == DISPARO);
    assign top_addr_fonte_out   = (state_q == DISPARO) ? fonte_q : '0;
    assign top_addr_destino_out = (state_q == DISPARO) ? destino_q : '0;
    assign erro_timeout_out     = (state_q == ERRO);
    assign erro_overflow_out    = ovf_q;
    assign ocupado_out          = (state_q != OCIOSO);

    // next-state, buffer bookkeeping and timeout counter
    always_comb begin
        state_d   = state_q;
        fonte_d   = fonte_q;
        destino_d = destino_q;
        wr_ptr_d  = wr_nxt;
        rd_ptr_d  = rd_nxt;
        count_d   = count_nxt;
        tmo_d     = tmo_q;
        ovf_d     = ovf_q || (push_req && !push);
        case (state_q)
            OCIOSO: begin
                if (req_valid_in) begin
                    fonte_d   = req_fonte_in;
                    destino_d = req_destino_in;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = RD_INICIAL;
                    count_d   = '0;
                    tmo_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = DISPARO;
                end
            end
            DISPARO: begin
                tmo_d   = tmo_q + 1'b1;
                state_d = AGUARDA;
            end
            AGUARDA: begin
                tmo_d = tmo_q + 1'b1;
                if (cam_pronto_in) begin
                    state_d = (count_nxt == '0) ? OCIOSO : ESVAZIA;
                end else if (tmo_q == TMO_ULTIMO) begin
                    state_d = ERRO;
                end
            end
            ESVAZIA: begin
                if ((count_q == '0) || (pop && out_last_out)) begin
                    state_d = OCIOSO;
                end
            end
            ERRO: begin
                wr_ptr_d = '0;
                rd_ptr_d = RD_INICIAL;
                count_d  = '0;
                state_d  = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OCIOSO;
            fonte_q   <= '0;
            destino_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= RD_INICIAL;
            count_q   <= '0;
            tmo_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fonte_q   <= fonte_d;
            destino_q <= destino_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
        end
    end

    // path storage; contents are only meaningful below count_q so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cam_addr_in;
        end
    end
endmodule

// File: tb/tb_controlador_requisicoes.sv
// Scoreboard bench for controlador_requisicoes: a driver issues requests and
// path nodes and queues the expected engine command and output stream; a
// monitor pops and compares whenever the DUT presents them.
module tb_controlador_requisicoes;
    localparam int AW   = 6;
    localparam int MAXC = 4;
    localparam int TMO  = 100;

    typedef logic [AW-1:0] addr_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_in = 1'b0;
    logic          req_ready_out;
    logic [AW-1:0] req_fonte_in = '0;
    logic [AW-1:0] req_destino_in = '0;
    logic          top_wr_fonte_out;
    logic [AW-1:0] top_addr_fonte_out;
    logic [AW-1:0] top_addr_destino_out;
    logic          cam_valid_in = 1'b0;
    logic [AW-1:0] cam_addr_in = '0;
    logic          cam_pronto_in = 1'b0;
    logic          out_valid_out;
    logic          out_ready_in = 1'b0;
    logic [AW-1:0] out_addr_out;
    logic          out_last_out;
    logic          erro_timeout_out;
    logic          erro_overflow_out;
    logic          ocupado_out;

    always #5 clk = ~clk;

    controlador_requisicoes #(
        .ADDR_WIDTH    (AW),
        .MAX_CAMINHO   (MAXC),
        .TIMEOUT_WIDTH (20),
        .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_fonte_in        (req_fonte_in),
        .req_destino_in      (req_destino_in),
        .top_wr_fonte_out    (top_wr_fonte_out),
        .top_addr_fonte_out  (top_addr_fonte_out),
        .top_addr_destino_out(top_addr_destino_out),
        .cam_valid_in        (cam_valid_in),
        .cam_addr_in         (cam_addr_in),
        .cam_pronto_in       (cam_pronto_in),
        .out_valid_out       (out_valid_out),
        .out_ready_in        (out_ready_in),
        .out_addr_out        (out_addr_out),
        .out_last_out        (out_last_out),
        .erro_timeout_out    (erro_timeout_out),
        .erro_overflow_out   (erro_overflow_out),
        .ocupado_out         (ocupado_out)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [AW:0]     exp_q[$];     // {last, addr}
    logic [2*AW-1:0] start_q[$];   // {fonte, destino}
    int              rdy_mode = 2; // 0 random, 1 toggle, 2 always, 3 never
    bit              prev_stall = 1'b0;
    logic [AW:0]     prev_elem;
    logic [AW:0]     e;
    logic [2*AW-1:0] s;

    function automatic void check(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // consumer ready pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready_in = 1'($urandom_range(0, 1));
            1:       out_ready_in = !out_ready_in;
            2:       out_ready_in = 1'b1;
            default: out_ready_in = 1'b0;
        endcase
    end

    // monitor: output stream, stall stability and engine command
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(out_valid_out), 1);
                check("stall_elem", int'({out_last_out, out_addr_out}), int'(prev_elem));
            end
            if (out_valid_out && out_ready_in) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got addr %0d last %0d, expected no output", out_addr_out, out_last_out);
                end else begin
                    e = exp_q.pop_front();
                    check("out_elem", int'({out_last_out, out_addr_out}), int'(e));
                end
            end
            prev_stall = out_valid_out && !out_ready_in;
            prev_elem  = {out_last_out, out_addr_out};
            if (top_wr_fonte_out) begin
                if (start_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: got %0d/%0d, expected no pulse", top_addr_fonte_out, top_addr_destino_out);
                end else begin
                    s = start_q.pop_front();
                    check("start_cmd", int'({top_addr_fonte_out, top_addr_destino_out}), int'(s));
                end
            end else begin
                check("idle_cmd", int'({top_addr_fonte_out, top_addr_destino_out}), 0);
            end
        end
    end

    // returns after the start-pulse cycle, in the first capture cycle
    task automatic send_req(input logic [AW-1:0] f, input logic [AW-1:0] d);
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (req_ready_out) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_ready_wait", int'(ok), 1);
        start_q.push_back({f, d});
        req_valid_in   = 1'b1;
        req_fonte_in   = f;
        req_destino_in = d;
        tick();
        req_valid_in = 1'b0;
        check("busy_after_accept", int'(ocupado_out), 1);
        tick();
    endtask

    task automatic run_path(input logic [AW-1:0] f, input logic [AW-1:0] d,
                            input addr_q_t nodes, input bit same_cycle,
                            input int cap_mode, input int drain_mode);
        addr_q_t kept;
        addr_q_t ordem;
        bit      exp_ovf;
        bit      done = 1'b0;
        // with the consumer stalled, only the first MAXC nodes fit
        foreach (nodes[i]) begin
            if (cap_mode != 3 || kept.size() < MAXC) kept.push_back(nodes[i]);
        end
        exp_ovf = (nodes.size() > kept.size());
`ifdef INVERTER_CAMINHO_EN
        for (int i = kept.size() - 1; i >= 0; i--) ordem.push_back(kept[i]);
`else
        ordem = kept;
`endif
        foreach (ordem[i]) exp_q.push_back({1'(i == ordem.size() - 1), ordem[i]});
        rdy_mode = cap_mode;
        send_req(f, d);
        foreach (nodes[i]) begin
            cam_valid_in = 1'b1;
            cam_addr_in  = nodes[i];
            if (same_cycle && i == nodes.size() - 1) cam_pronto_in = 1'b1;
            tick();
            cam_valid_in  = 1'b0;
            cam_pronto_in = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        if (!same_cycle || nodes.size() == 0) begin
            cam_pronto_in = 1'b1;
            tick();
            cam_pronto_in = 1'b0;
        end
        rdy_mode = drain_mode;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !ocupado_out) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("path_complete", int'(done), 1);
        if (!done) begin
            $display("FAIL drain_timeout: got %0d pending nodes, expected 0", exp_q.size());
            exp_q.delete();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
        end
        check("overflow_flag", int'(erro_overflow_out), int'(exp_ovf));
        check("ready_after_path", int'(req_ready_out), 1);
    endtask

    initial begin
        addr_q_t q;
        int      cyc;
        tick();
        tick();
        check("reset_ready", int'(req_ready_out), 0);
        check("reset_outs", int'({top_wr_fonte_out, out_valid_out, out_last_out, erro_timeout_out,
                                  erro_overflow_out, ocupado_out, out_addr_out}), 0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", int'(req_ready_out), 1);

        // basic request, streaming consumer
        q = '{6'd40, 6'd33, 6'd12, 6'd3};
        run_path(6'd3, 6'd40, q, 1'b0, 2, 2);
        // backpressure: drain with toggling ready
        run_path(6'd3, 6'd40, q, 1'b0, 3, 1);
        // same-cycle capture of the final node
        q = '{6'd5};
        run_path(6'd5, 6'd20, q, 1'b1, 2, 2);
        q = '{6'd9, 6'd17, 6'd5};
        run_path(6'd5, 6'd9, q, 1'b1, 0, 1);
        // pronto with an empty buffer
        q = {};
        run_path(6'd1, 6'd1, q, 1'b0, 2, 2);

        // timeout: no pronto after the start pulse
        send_req(6'd11, 6'd22);
        cyc = 0;
        for (int k = 0; k < 300; k++) begin
            if (erro_timeout_out) break;
            tick();
            cyc++;
        end
        check("timeout_cycles", cyc + 1, TMO);
        tick();
        check("timeout_pulse_width", int'(erro_timeout_out), 0);
        check("ready_after_timeout", int'(req_ready_out), 1);

        // overflow: six nodes into a four-deep buffer with a stalled consumer
        q = '{6'd60, 6'd50, 6'd40, 6'd30, 6'd20, 6'd10};
        run_path(6'd10, 6'd60, q, 1'b0, 3, 0);
        q = '{6'd2, 6'd4};
        run_path(6'd4, 6'd2, q, 1'b0, 2, 2);

        // reset in the middle of a capture
        rdy_mode = 3;
        send_req(6'd7, 6'd9);
        for (int i = 0; i < 2; i++) begin
            cam_valid_in = 1'b1;
            cam_addr_in  = AW'(i + 30);
            tick();
        end
        cam_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        check("midrun_reset_outs", int'({req_ready_out, top_wr_fonte_out, out_valid_out, out_last_out,
                                         erro_timeout_out, erro_overflow_out, ocupado_out,
                                         out_addr_out, top_addr_fonte_out, top_addr_destino_out}), 0);
        rst = 1'b0;
        tick();
        tick();
        check("midrun_no_pulse", int'(ocupado_out), 0);
        check("midrun_ready", int'(req_ready_out), 1);
        q = '{6'd9, 6'd8, 6'd7};
        run_path(6'd7, 6'd9, q, 1'b0, 0, 0);

        // randomized paths
        for (int r = 0; r < 25; r++) begin
            int n;
            q = {};
            n = $urandom_range(0, MAXC);
            for (int i = 0; i < n; i++) q.push_back(AW'($urandom_range(0, 63)));
            run_path(AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)), q,
                     1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        tick();
        check("start_queue_empty", start_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/controlador_requisicoes.md
# controlador_requisicoes

Host-side initiator for the shortest-path engine. Accepts (fonte, destino) requests over a valid/ready handshake, issues the one-cycle start command to `top`, captures the path node addresses emitted by the predecessor-memory manager, and returns them as a buffered stream with an end marker. It also enforces a completion timeout and reports path-buffer overflow.

## Interface
Parameters:
- `ADDR_WIDTH`, 6, node address width (matches `ADDR_WIDTH`)
- `MAX_CAMINHO`, 64, path buffer depth in nodes (power of two)
- `TIMEOUT_WIDTH`, 20, width of the completion-timeout counter
- `TIMEOUT_CICLOS`, 500000, cycles from start pulse to forced error

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock
  - `rst` in 1: reset
- Request channel:
  - `req_valid_in` in 1: request valid
  - `req_ready_out` out 1: block idle, can accept
  - `req_fonte_in` in ADDR_WIDTH: source node
  - `req_destino_in` in ADDR_WIDTH: destination node
- Engine start command:
  - `top_wr_fonte_out` out 1: start pulse to engine
  - `top_addr_fonte_out` out ADDR_WIDTH: source to engine, 0 when not pulsing
  - `top_addr_destino_out` out ADDR_WIDTH: destination to engine, 0 when not pulsing
- Path capture:
  - `cam_valid_in` in 1: path node valid (engine path-read strobe)
  - `cam_addr_in` in ADDR_WIDTH: path node address
  - `cam_pronto_in` in 1: path generation finished
- Path output:
  - `out_valid_out` out 1: output node valid
  - `out_ready_in` in 1: consumer ready
  - `out_addr_out` out ADDR_WIDTH: node address
  - `out_last_out` out 1: final node of path
- Status:
  - `erro_timeout_out` out 1: one-cycle pulse on timeout
  - `erro_overflow_out` out 1: sticky until next accepted request
  - `ocupado_out` out 1: high in any state except OCIOSO

## Operation
- FSM states: OCIOSO, DISPARO, AGUARDA, ESVAZIA, ERRO.
- OCIOSO: `req_ready_out`=1. On `req_valid_in`&`req_ready_out`, latch fonte/destino, clear buffer, count, timeout counter and `erro_overflow_out`; go to DISPARO.
- DISPARO (exactly 1 cycle): `top_wr_fonte_out`=1 with latched addresses; go to AGUARDA.
- AGUARDA: each `cam_valid_in` writes `cam_addr_in` into the buffer. The timeout counter increments each cycle.
  - `cam_pronto_in` moves the FSM to ESVAZIA.
  - Counter reaching `TIMEOUT_CICLOS`-1 without pronto moves it to ERRO.
  - `cam_valid_in` and `cam_pronto_in` in the same cycle: the node is captured and is the last node.
- Buffer full while `cam_valid_in`: node dropped, `erro_overflow_out` set; the path still completes with the stored nodes.
- ESVAZIA: drains the buffer. Returns to OCIOSO on the handshake of the `out_last_out` element.
  - Pronto with an empty buffer: return to OCIOSO directly, no output.
- ERRO (1 cycle): `erro_timeout_out`=1, buffer flushed, go to OCIOSO.
- `cam_*` inputs are ignored in OCIOSO, DISPARO and ERRO.
- Output element holds stable while `out_valid_out`&!`out_ready_in`.
- Widths: count register is log2(MAX_CAMINHO)+1 bits; pointers wrap modulo MAX_CAMINHO.

## Timing
- Reset values: `req_ready_out`=0 during reset, 1 the cycle after. All other outputs 0. FSM=OCIOSO.
- Request accepted at edge N: `top_wr_fonte_out` is high for cycle N+1 only. AGUARDA starts at N+2.
- Captured node visible on `out_*` no earlier than 1 cycle after capture.
- FIFO mode (macro undefined): streaming during AGUARDA.
  - An element is presented only when the buffer holds ≥2 entries, or pronto has been seen.
  - This guarantees `out_last_out` lands on the final element.
- Full buffer: simultaneous read and write in the same cycle succeeds.
- `rst` mid-operation: immediate return to reset values; no start pulse is issued afterwards.

## Configuration
- `INVERTER_CAMINHO_EN` defined: the buffer acts as a LIFO. Nothing is output during AGUARDA. In ESVAZIA, nodes are emitted in reverse capture order (source→destination).
- Undefined: the buffer is a FIFO and emits nodes in capture order (destination→source), streaming as described in Timing.

## Test plan
- Basic request: request fonte=3, destino=40, then feed nodes 40,33,12,3 and a pronto pulse.
  - `top_wr_fonte_out` is a single pulse carrying 3/40.
  - Output is 40,33,12,3 with last on 3, or 3,12,33,40 with `INVERTER_CAMINHO_EN`.
- Backpressure: `out_ready_in` toggles 1/0 every cycle during the drain.
  - No node is lost or duplicated; `out_addr_out` is stable while stalled.
- Same-cycle capture: `cam_valid_in` carries 5 in the same cycle as `cam_pronto_in`.
  - Node 5 is emitted with `out_last_out`=1.
- Timeout: no pronto after the start pulse, with `TIMEOUT_CICLOS`=100.
  - `erro_timeout_out` pulses 100 cycles after the start pulse; `req_ready_out` returns high the next cycle.
- Overflow: `MAX_CAMINHO`=4, capture 6 nodes, then pronto.
  - `erro_overflow_out`=1; only the first 4 nodes are emitted.
- Reset mid-run: assert `rst` in AGUARDA after 2 nodes.
  - All outputs return to 0; a new request then produces a clean run.
